// File: rtl/wb_stage_if.sv
// wb_stage_if: memory-to-write-back handshake and write-back control bundle.
//   master : memory-stage side; drives ms_to_ws_valid/ms_to_ws_bus and observes
//            ws_allowin plus the write-back status (ws_valid, ws_dest,
//            ws_handle_ex, ws_flush_pc).
//   slave  : write-back side; the mirror image of master.
interface wb_stage_if;
    logic         ms_to_ws_valid;
    logic [154:0] ms_to_ws_bus;
    logic         ws_allowin;
    logic         ws_valid;
    logic [4:0]   ws_dest;
    logic         ws_handle_ex;
    logic [31:0]  ws_flush_pc;

    modport master (
        output ms_to_ws_valid, ms_to_ws_bus,
        input  ws_allowin, ws_valid, ws_dest, ws_handle_ex, ws_flush_pc
    );

    modport slave (
        input  ms_to_ws_valid, ms_to_ws_bus,
        output ws_allowin, ws_valid, ws_dest, ws_handle_ex, ws_flush_pc
    );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: MIPS write-back stage with CP0 (BadVAddr/Count/Compare/Status/Cause/EPC),
// exception/interrupt/ERET commit, pipeline flush and fetch redirect.
//   clk, resetn        : clock, asynchronous active-low reset
//   ws (slave)         : ms_to_ws_valid/bus in; ws_allowin, ws_valid, ws_dest,
//                        ws_handle_ex, ws_flush_pc out
//   ext_int[5:0]       : level-sensitive hardware interrupt lines
//   rf_we/waddr/wdata  : register-file write port with byte enables
//   debug_wb_*         : trace mirroring the write port
// Optional feature: CP0_TIMER_EN adds the Count/Compare timer and Cause.TI.
module wb_stage (
    input  logic        clk,
    input  logic        resetn,
    wb_stage_if.slave   ws,
    input  logic [5:0]  ext_int,
    output logic [3:0]  rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);
    // CP0 addresses encoded as {rd, sel}
    localparam logic [7:0] A_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] A_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] A_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] A_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] A_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] A_EPC      = {5'd14, 3'd0};
    localparam logic [31:0] EX_ENTRY  = 32'hBFC0_0380;

    logic [154:0] bus_r;
    logic         valid_r;
    logic         allowin;

    logic         f_ex;
    logic [4:0]   f_exccode;
    logic         f_bd;
    logic [31:0]  f_badvaddr;
    logic         f_eret;
    logic         f_mtc0;
    logic [7:0]   f_cp0_addr;
    logic [31:0]  f_cp0_wdata;
    logic         f_res_cp0;
    logic [3:0]   f_rf_we;
    logic [4:0]   f_dest;
    logic [31:0]  f_result;
    logic [31:0]  f_pc;

    logic [7:0]   st_im;
    logic         st_exl;
    logic         st_ie;
    logic         ca_bd;
    logic         ca_ti;
    logic [5:0]   ca_ip_hw;
    logic [1:0]   ca_ip_sw;
    logic [4:0]   ca_exc;
    logic [31:0]  epc;
    logic [31:0]  badvaddr;
    logic [31:0]  count_rd;
    logic [31:0]  compare_rd;

    logic         int_pending;
    logic         take_ex;
    logic         do_eret;
    logic         handle_ex;
    logic         mtc0_we;
    logic [4:0]   ex_code;
    logic [31:0]  status_rd;
    logic [31:0]  cause_rd;
    logic [31:0]  cp0_rdata;

    assign {f_ex, f_exccode, f_bd, f_badvaddr, f_eret, f_mtc0, f_cp0_addr, f_cp0_wdata,
            f_res_cp0, f_rf_we, f_dest, f_result, f_pc} = bus_r;

    // Ready_go is always 1, so the stage can always take a new instruction
    assign allowin = 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_r <= 1'b0;
            bus_r   <= '0;
        end else begin
            valid_r <= handle_ex ? 1'b0 : ws.ms_to_ws_valid;
            if (ws.ms_to_ws_valid && allowin)
                bus_r <= ws.ms_to_ws_bus;
        end
    end

    assign int_pending = valid_r && st_ie && !st_exl && |({ca_ip_hw, ca_ip_sw} & st_im);
    assign take_ex     = valid_r && (int_pending || f_ex);
    assign do_eret     = valid_r && f_eret && !take_ex;
    assign handle_ex   = valid_r && (f_ex || f_eret || int_pending);
    assign mtc0_we     = valid_r && f_mtc0 && !handle_ex;
    assign ex_code     = int_pending ? 5'h00 : f_exccode;

    assign status_rd = {9'd0, 1'b1, 6'd0, st_im, 6'd0, st_exl, st_ie};
    assign cause_rd  = {ca_bd, ca_ti, 14'd0, ca_ip_hw, ca_ip_sw, 1'b0, ca_exc, 2'b00};

    // Exception/interrupt commit outranks ERET, which outranks MTC0
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_im    <= 8'd0;
            st_exl   <= 1'b0;
            st_ie    <= 1'b0;
            ca_bd    <= 1'b0;
            ca_ip_hw <= 6'd0;
            ca_ip_sw <= 2'd0;
            ca_exc   <= 5'd0;
            epc      <= 32'd0;
            badvaddr <= 32'd0;
        end else begin
            ca_ip_hw <= {ext_int[5] | ca_ti, ext_int[4:0]};
            if (take_ex) begin
                if (!st_exl) begin
                    epc   <= f_bd ? f_pc - 32'd4 : f_pc;
                    ca_bd <= f_bd;
                end
                st_exl <= 1'b1;
                ca_exc <= ex_code;
                if (ex_code == 5'h04 || ex_code == 5'h05)
                    badvaddr <= f_badvaddr;
            end else if (do_eret) begin
                st_exl <= 1'b0;
            end else if (mtc0_we) begin
                if (f_cp0_addr == A_STATUS) begin
                    st_im  <= f_cp0_wdata[15:8];
                    st_exl <= f_cp0_wdata[1];
                    st_ie  <= f_cp0_wdata[0];
                end
                if (f_cp0_addr == A_CAUSE)
                    ca_ip_sw <= f_cp0_wdata[9:8];
                if (f_cp0_addr == A_EPC)
                    epc <= f_cp0_wdata;
            end
        end
    end

`ifdef CP0_TIMER_EN
    logic        tick;
    logic [31:0] count;
    logic [31:0] compare;
    logic        wr_count;
    logic        wr_compare;

    assign wr_count   = mtc0_we && f_cp0_addr == A_COUNT;
    assign wr_compare = mtc0_we && f_cp0_addr == A_COMPARE;

    // Count advances on every other cycle; a software write replaces the increment.
    // TI compares the registered (post-MTC0) values; writing Compare always clears it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick    <= 1'b0;
            count   <= 32'd0;
            compare <= 32'd0;
            ca_ti   <= 1'b0;
        end else begin
            tick    <= ~tick;
            count   <= wr_count ? f_cp0_wdata : count + {31'd0, tick};
            compare <= wr_compare ? f_cp0_wdata : compare;
            ca_ti   <= wr_compare ? 1'b0 : (count == compare) ? 1'b1 : ca_ti;
        end
    end

    assign count_rd   = count;
    assign compare_rd = compare;
`else
    assign ca_ti      = 1'b0;
    assign count_rd   = 32'd0;
    assign compare_rd = 32'd0;
`endif

    assign cp0_rdata = (f_cp0_addr == A_STATUS)   ? status_rd  :
                       (f_cp0_addr == A_CAUSE)    ? cause_rd   :
                       (f_cp0_addr == A_EPC)      ? epc        :
                       (f_cp0_addr == A_BADVADDR) ? badvaddr   :
                       (f_cp0_addr == A_COUNT)    ? count_rd   :
                       (f_cp0_addr == A_COMPARE)  ? compare_rd : 32'd0;

    assign rf_we    = {4{valid_r && !handle_ex}} & f_rf_we;
    assign rf_waddr = f_dest;
    assign rf_wdata = f_res_cp0 ? cp0_rdata : f_result;

    assign debug_wb_pc       = f_pc;
    assign debug_wb_rf_wen   = rf_we;
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

    assign ws.ws_allowin   = allowin;
    assign ws.ws_valid     = valid_r;
    assign ws.ws_dest      = (rf_we != 4'd0) ? f_dest : 5'd0;
    assign ws.ws_handle_ex = handle_ex;
    assign ws.ws_flush_pc  = do_eret ? epc : EX_ENTRY;
endmodule
